// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and type definitions for the memory port arbiter slice.
package mem_port_arbiter_pkg;

    localparam int unsigned WORD_SIZE_C  = 16;
    localparam int unsigned LATENCY_C    = 4;
    localparam int unsigned LINE_WIDTH_C = 4 * WORD_SIZE_C;

    // Wide enough for LATENCY-1 over the legal LATENCY range 1..7.
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Cache-side and memory-side signals of the shared line port.
interface mem_port_arbiter_if #(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned LINE_WIDTH = 64
);

    logic                  i_read_req;
    logic [WORD_SIZE-1:0]  i_addr;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_done;

    logic                  d_read_req;
    logic                  d_write_req;
    logic [WORD_SIZE-1:0]  d_addr;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_done;

    logic                  mem_read;
    logic                  mem_write;
    logic [WORD_SIZE-1:0]  mem_addr;
    logic [LINE_WIDTH-1:0] mem_wdata;
    logic [LINE_WIDTH-1:0] mem_rdata;

    logic                  busy;
    logic [WORD_SIZE-1:0]  num_i_access;
    logic [WORD_SIZE-1:0]  num_d_access;

    // Arbiter side
    modport slave (
        input  i_read_req, i_addr,
        input  d_read_req, d_write_req, d_addr, d_wdata,
        input  mem_rdata,
        output i_rdata, i_done, d_rdata, d_done,
        output mem_read, mem_write, mem_addr, mem_wdata,
        output busy, num_i_access, num_d_access
    );

    // Cache / memory side
    modport master (
        output i_read_req, i_addr,
        output d_read_req, d_write_req, d_addr, d_wdata,
        output mem_rdata,
        input  i_rdata, i_done, d_rdata, d_done,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        input  busy, num_i_access, num_d_access
    );

endinterface

// File: rtl/mem_port_arbiter_latency_counter.sv
// Fixed-latency access counter with clear, enable and terminal-count flag.
module latency_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned LATENCY = LATENCY_C,
    parameter int unsigned WIDTH   = CNT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [WIDTH-1:0] count;

    // Count up while enabled; clear has priority so the count restarts at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == WIDTH'(LATENCY - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of the single line-wide memory port between I- and D-cache.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned LATENCY    = LATENCY_C,
    parameter int unsigned WORD_SIZE  = WORD_SIZE_C,
    parameter int unsigned LINE_WIDTH = LINE_WIDTH_C
) (
    input logic               clk,
    input logic               reset_n,
    mem_port_arbiter_if.slave bus
);

    localparam logic [WORD_SIZE-1:0] ADDR_MASK = ~WORD_SIZE'(3);

    arb_state_t            state_q;
    grant_t                grant_q;
    grant_t                last_grant_q;

    logic                  mem_read_q;
    logic                  mem_write_q;
    logic [WORD_SIZE-1:0]  mem_addr_q;
    logic [LINE_WIDTH-1:0] mem_wdata_q;
    logic [LINE_WIDTH-1:0] i_rdata_q;
    logic [LINE_WIDTH-1:0] d_rdata_q;
    logic                  i_done_q;
    logic                  d_done_q;
    logic [WORD_SIZE-1:0]  num_i_q;
    logic [WORD_SIZE-1:0]  num_d_q;

    logic                  i_pend;
    logic                  d_pend;
    logic                  pick_d;
    logic                  lat_en;
    logic                  lat_clear;
    logic                  lat_tc;

    // Pending flags and round-robin pick: on a tie the side not granted last wins.
    always_comb begin
        i_pend    = bus.i_read_req;
        d_pend    = bus.d_read_req | bus.d_write_req;
        pick_d    = d_pend && (!i_pend || (last_grant_q == GNT_I));
        lat_en    = (state_q == BUSY);
        lat_clear = (state_q == BUSY) && lat_tc;
    end

    latency_counter #(
        .LATENCY (LATENCY),
        .WIDTH   (CNT_W)
    ) u_lat (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (lat_clear),
        .enable   (lat_en),
        .terminal (lat_tc)
    );

    // Grant / access / response sequencing with all port outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= GNT_I;
            last_grant_q <= GNT_I;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            num_i_q      <= '0;
            num_d_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    i_done_q <= 1'b0;
                    d_done_q <= 1'b0;
                    if (i_pend || d_pend) begin
                        state_q <= BUSY;
                        if (pick_d) begin
                            grant_q      <= GNT_D;
                            last_grant_q <= GNT_D;
                            mem_addr_q   <= bus.d_addr & ADDR_MASK;
                            mem_wdata_q  <= bus.d_wdata;
                            // A write request overrides a simultaneous read.
                            mem_write_q  <= bus.d_write_req;
                            mem_read_q   <= !bus.d_write_req;
                            num_d_q      <= num_d_q + 1'b1;
                        end else begin
                            grant_q      <= GNT_I;
                            last_grant_q <= GNT_I;
                            mem_addr_q   <= bus.i_addr & ADDR_MASK;
                            mem_wdata_q  <= '0;
                            mem_write_q  <= 1'b0;
                            mem_read_q   <= 1'b1;
                            num_i_q      <= num_i_q + 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (lat_tc) begin
                        state_q     <= RESP;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (mem_read_q) begin
                            if (grant_q == GNT_D) begin
                                d_rdata_q <= bus.mem_rdata;
                            end else begin
                                i_rdata_q <= bus.mem_rdata;
                            end
                        end
                        i_done_q <= (grant_q == GNT_I);
                        d_done_q <= (grant_q == GNT_D);
                    end
                end
                RESP: begin
                    state_q  <= IDLE;
                    i_done_q <= 1'b0;
                    d_done_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_read     = mem_read_q;
    assign bus.mem_write    = mem_write_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.i_rdata      = i_rdata_q;
    assign bus.d_rdata      = d_rdata_q;
    assign bus.i_done       = i_done_q;
    assign bus.d_done       = d_done_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.num_i_access = num_i_q;
    assign bus.num_d_access = num_d_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a
// transaction-level model (phase count since grant, owner, captured lines).
module tb_mem_port_arbiter;

    localparam int L = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.WORD_SIZE(16), .LINE_WIDTH(64)) bus ();

    mem_port_arbiter #(
        .LATENCY    (L),
        .WORD_SIZE  (16),
        .LINE_WIDTH (64)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: ph = 0 when no transfer is active, else cycles elapsed since grant
    // (1..L access cycles, L+1 the done cycle).
    int          ph;
    logic        own_d;
    logic        m_wr;
    logic        last_d;
    logic [15:0] m_addr;
    logic [63:0] m_wdata;
    logic [63:0] e_i_rdata;
    logic [63:0] e_d_rdata;
    logic [15:0] e_ni;
    logic [15:0] e_nd;
    logic        fin_i;
    logic        fin_d;

    int obs_reads;
    int obs_writes;
    int edge_idx;
    int i_edges[$];
    int d_edges[$];
    bit rand_mode = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph        = 0;
        own_d     = 1'b0;
        m_wr      = 1'b0;
        last_d    = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        e_i_rdata = '0;
        e_d_rdata = '0;
        e_ni      = '0;
        e_nd      = '0;
        fin_i     = 1'b0;
        fin_d     = 1'b0;
    endtask

    task automatic model_step();
        logic pi;
        logic pd;
        fin_i = 1'b0;
        fin_d = 1'b0;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (ph == 0) begin
            pi = bus.i_read_req;
            pd = bus.d_read_req | bus.d_write_req;
            if (pi || pd) begin
                own_d  = pd && (!pi || !last_d);
                last_d = own_d;
                ph     = 1;
                if (own_d) begin
                    m_wr    = bus.d_write_req;
                    m_addr  = bus.d_addr & 16'hFFFC;
                    m_wdata = bus.d_wdata;
                    e_nd    = e_nd + 16'd1;
                end else begin
                    m_wr    = 1'b0;
                    m_addr  = bus.i_addr & 16'hFFFC;
                    e_ni    = e_ni + 16'd1;
                end
            end
        end else if (ph == L + 1) begin
            ph = 0;
            if (own_d) fin_d = 1'b1;
            else       fin_i = 1'b1;
        end else begin
            if (ph == L && !m_wr) begin
                if (own_d) e_d_rdata = bus.mem_rdata;
                else       e_i_rdata = bus.mem_rdata;
            end
            ph++;
        end
    endtask

    task automatic compare_all();
        logic exp_rd;
        logic exp_wr;
        exp_rd = (ph >= 1) && (ph <= L) && !m_wr;
        exp_wr = (ph >= 1) && (ph <= L) && m_wr;
        check("mem_read",  64'(bus.mem_read),  64'(exp_rd));
        check("mem_write", 64'(bus.mem_write), 64'(exp_wr));
        check("busy",      64'(bus.busy),      64'(ph != 0));
        check("i_done",    64'(bus.i_done),    64'((ph == L + 1) && !own_d));
        check("d_done",    64'(bus.d_done),    64'((ph == L + 1) && own_d));
        check("i_rdata",   bus.i_rdata,        e_i_rdata);
        check("d_rdata",   bus.d_rdata,        e_d_rdata);
        check("num_i",     64'(bus.num_i_access), 64'(e_ni));
        check("num_d",     64'(bus.num_d_access), 64'(e_nd));
        if (ph >= 1 && ph <= L) check("mem_addr", 64'(bus.mem_addr), 64'(m_addr));
        if (exp_wr) check("mem_wdata", bus.mem_wdata, m_wdata);
    endtask

    task automatic agents();
        logic i_own;
        logic d_own;
        logic d_any;
        int   kind;
        i_own = (ph != 0) && !own_d;
        d_own = (ph != 0) && own_d;
        d_any = bus.d_read_req | bus.d_write_req;
        if (!bus.i_read_req && !fin_i) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.i_read_req = 1'b1;
                bus.i_addr     = 16'($urandom);
            end
        end else if (bus.i_read_req && !i_own && $urandom_range(0, 3) == 0) begin
            bus.i_addr = 16'($urandom);
        end
        if (!d_any && !fin_d) begin
            if ($urandom_range(0, 3) == 0) begin
                kind            = int'($urandom_range(0, 2));
                bus.d_read_req  = (kind != 1);
                bus.d_write_req = (kind != 0);
                bus.d_addr      = 16'($urandom);
                bus.d_wdata     = {$urandom, $urandom};
            end
        end else if (d_any && !d_own && $urandom_range(0, 3) == 0) begin
            bus.d_addr  = 16'($urandom);
            bus.d_wdata = {$urandom, $urandom};
        end
        bus.mem_rdata = {$urandom, $urandom};
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        if (bus.mem_read)  obs_reads++;
        if (bus.mem_write) obs_writes++;
        if (bus.i_done) i_edges.push_back(edge_idx);
        if (bus.d_done) d_edges.push_back(edge_idx);
        edge_idx++;
        if (fin_i) bus.i_read_req = 1'b0;
        if (fin_d) begin
            bus.d_read_req  = 1'b0;
            bus.d_write_req = 1'b0;
        end
        if (rand_mode) agents();
    endtask

    task automatic obs_clear();
        obs_reads  = 0;
        obs_writes = 0;
        edge_idx   = 0;
        i_edges.delete();
        d_edges.delete();
    endtask

    task automatic wait_quiet(input string nm, input int budget);
        int n;
        n = 0;
        while ((ph != 0 || bus.i_read_req || bus.d_read_req || bus.d_write_req) && n < budget) begin
            cycle();
            n++;
        end
        check(nm, 64'(ph == 0 && !bus.i_read_req && !bus.d_read_req && !bus.d_write_req), 64'd1);
    endtask

    task automatic clear_inputs();
        bus.i_read_req  = 1'b0;
        bus.i_addr      = '0;
        bus.d_read_req  = 1'b0;
        bus.d_write_req = 1'b0;
        bus.d_addr      = '0;
        bus.d_wdata     = '0;
        bus.mem_rdata   = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        clear_inputs();
        model_reset();
        cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        clear_inputs();
        model_reset();
        obs_clear();

        // Reset state
        cycle();
        check("rst_mem_addr", 64'(bus.mem_addr), 64'h0);
        check("rst_mem_wdata", bus.mem_wdata, 64'h0);
        check("rst_busy", 64'(bus.busy), 64'h0);
        reset_n = 1'b1;

        // I-only read
        obs_clear();
        bus.i_read_req = 1'b1;
        bus.i_addr     = 16'h0013;
        bus.mem_rdata  = 64'h1111_2222_3333_4444;
        cycle();
        check("t1_addr", 64'(bus.mem_addr), 64'h0010);
        check("t1_read", 64'(bus.mem_read), 64'h1);
        wait_quiet("t1_quiet", 20);
        check("t1_reads", 64'(obs_reads), 64'd4);
        check("t1_idone_n", 64'(i_edges.size()), 64'd1);
        check("t1_idone_at", 64'(i_edges[0]), 64'd4);
        check("t1_i_rdata", bus.i_rdata, 64'h1111_2222_3333_4444);

        // D write
        obs_clear();
        bus.d_write_req = 1'b1;
        bus.d_addr      = 16'h0027;
        bus.d_wdata     = 64'hAAAA_BBBB_CCCC_DDDD;
        bus.mem_rdata   = 64'hDEAD_BEEF_0000_5555;
        cycle();
        check("t2_addr", 64'(bus.mem_addr), 64'h0024);
        check("t2_wdata", bus.mem_wdata, 64'hAAAA_BBBB_CCCC_DDDD);
        wait_quiet("t2_quiet", 20);
        check("t2_writes", 64'(obs_writes), 64'd4);
        check("t2_reads", 64'(obs_reads), 64'd0);
        check("t2_ddone_n", 64'(d_edges.size()), 64'd1);
        check("t2_d_rdata", bus.d_rdata, 64'h0);
        check("t2_num_d", 64'(bus.num_d_access), 64'd1);

        // Tie from reset: D first, then I ties with a fresh D request and wins
        do_reset();
        obs_clear();
        bus.i_read_req = 1'b1;
        bus.i_addr     = 16'h0100;
        bus.d_read_req = 1'b1;
        bus.d_addr     = 16'h0200;
        bus.mem_rdata  = 64'h0123_4567_89AB_CDEF;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!fin_d && k < 20);
        check("t3_dfin", 64'(fin_d), 64'd1);
        bus.d_read_req = 1'b1;
        bus.d_addr     = 16'h0300;
        wait_quiet("t3_quiet", 40);
        check("t3_d_first", 64'(d_edges[0]), 64'd4);
        check("t3_i_second", 64'(i_edges[0]), 64'd10);
        check("t3_d_third", 64'(d_edges[1]), 64'd16);
        check("t3_i_rdata", bus.i_rdata, 64'h0123_4567_89AB_CDEF);

        // Simultaneous D read and write: write wins, single done
        obs_clear();
        bus.d_read_req  = 1'b1;
        bus.d_write_req = 1'b1;
        bus.d_addr      = 16'h0033;
        bus.d_wdata     = 64'h0F0F_0F0F_F0F0_F0F0;
        bus.mem_rdata   = 64'h9999_8888_7777_6666;
        wait_quiet("t4_quiet", 20);
        check("t4_writes", 64'(obs_writes), 64'd4);
        check("t4_reads", 64'(obs_reads), 64'd0);
        check("t4_ddone_n", 64'(d_edges.size()), 64'd1);
        check("t4_num_d", 64'(bus.num_d_access), 64'd3);
        check("t4_d_rdata", bus.d_rdata, 64'h0123_4567_89AB_CDEF);

        // Reset in the second access cycle, request held and regranted
        obs_clear();
        bus.i_read_req = 1'b1;
        bus.i_addr     = 16'h0044;
        bus.mem_rdata  = 64'h5A5A_A5A5_1234_8765;
        cycle();
        cycle();
        reset_n = 1'b0;
        #1;
        check("t5_read", 64'(bus.mem_read), 64'h0);
        check("t5_busy", 64'(bus.busy), 64'h0);
        check("t5_num_i", 64'(bus.num_i_access), 64'h0);
        check("t5_i_rdata", bus.i_rdata, 64'h0);
        model_reset();
        cycle();
        reset_n = 1'b1;
        obs_clear();
        wait_quiet("t5_quiet", 20);
        check("t5_idone_n", 64'(i_edges.size()), 64'd1);
        check("t5_idone_at", 64'(i_edges[0]), 64'd4);
        check("t5_num_i_after", 64'(bus.num_i_access), 64'd1);
        check("t5_i_rdata_after", bus.i_rdata, 64'h5A5A_A5A5_1234_8765);

        // Grant counter wrap
        force dut.num_i_q = 16'hFFFF;
        e_ni = 16'hFFFF;
        #1;
        release dut.num_i_q;
        #1;
        check("t6_preload", 64'(bus.num_i_access), 64'hFFFF);
        bus.i_read_req = 1'b1;
        bus.i_addr     = 16'h0088;
        wait_quiet("t6_quiet", 20);
        check("t6_wrap", 64'(bus.num_i_access), 64'h0);

        // Random traffic
        do_reset();
        obs_clear();
        rand_mode = 1'b1;
        repeat (1500) cycle();
        rand_mode = 1'b0;
        wait_quiet("rand_drain", 60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single 64-bit (4-word line) memory port between the instruction cache (line fills) and the data cache (line fills and write-through line writes).
- Replaces direct cache-to-memory wiring; it is the only block that drives memory readM/writeM.
- Owns the fixed-latency access counter and returns a one-cycle done pulse per completed line transfer.

Parameters:
- LATENCY, 4, memory access latency in cycles; must match the `LATENCY constant; legal range 1..7.
- WORD_SIZE, 16, address and word width.
- LINE_WIDTH, 64, line width (4*WORD_SIZE).

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- i_read_req  in  1  I-cache line-fill request; held until i_done
- i_addr  in  16  I-cache request address (low 2 bits ignored)
- i_rdata  out  64  fill line for I-cache
- i_done  out  1  one-cycle pulse: I-cache transfer complete
- d_read_req  in  1  D-cache line-fill request; held until d_done
- d_write_req  in  1  D-cache line-write request; held until d_done
- d_addr  in  16  D-cache request address (low 2 bits ignored)
- d_wdata  in  64  D-cache line to write
- d_rdata  out  64  fill line for D-cache
- d_done  out  1  one-cycle pulse: D-cache transfer complete
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  16  line-aligned memory address
- mem_wdata  out  64  memory write line
- mem_rdata  in  64  memory read line, valid on the last BUSY cycle
- busy  out  1  high in BUSY and RESP
- num_i_access, num_d_access  out  16 each  grant counters for debug

Behaviour:
- Reset (async, reset_n=0): state=IDLE; count=0; last_grant=I; all outputs 0, including rdata registers and counters. A reset asserted mid-transfer aborts the access immediately, with no done pulse.
- States:
  - IDLE: on any request, grant, register mem_addr={addr[15:2],2'b00}, register mem_wdata and direction, then go to BUSY.
  - BUSY: mem_read or mem_write held high; count increments each cycle. When count==LATENCY-1, sample mem_rdata into the granted requester's rdata (reads only), clear count, and go to RESP.
  - RESP: the granted requester's done=1 for exactly this cycle; strobes low; then go to IDLE.
- Latency: a request seen in IDLE at edge 0 gives LATENCY BUSY cycles and done in cycle LATENCY+1. Back-to-back grants therefore have at least one IDLE cycle between them.
- Handshake:
  - A requester holds req and addr/wdata stable until it samples done=1, and drops req at that same edge.
  - Changes to req or addr while the requester is not granted are allowed.
  - Inputs of the granted requester are ignored after the grant edge, since they are registered.
- Arbitration:
  - Only one requester pending: it is granted.
  - Both pending: the requester not granted last wins (round-robin). last_grant resets to I, so D wins the first tie.
- Simultaneous d_read_req and d_write_req: the write is performed and the read is ignored; d_done pulses once.
- mem_read and mem_write are never high together. Both are low in IDLE and RESP.
- rdata registers hold their value until the next read completion for that requester. Writes do not alter d_rdata.
- Counters: num_i_access and num_d_access increment on each grant edge and wrap 0xFFFF→0x0000.
- No request in IDLE: remain in IDLE with all strobes low.

Decomposition:
- Shared constants (`WORD_SIZE, `LATENCY, line width, state encodings IDLE/BUSY/RESP, grant IDs GNT_I/GNT_D) belong in constants.v.
- One natural sub-module: latency_counter (load/clear, enable, terminal-count flag at LATENCY-1), reusable by the caches' write paths.

Test Plan:
- I-only read, i_addr=0x0013, mem_rdata=0x1111_2222_3333_4444 → mem_addr=0x0010, mem_read high for 4 cycles, i_rdata=that line, i_done one pulse in cycle 5.
- D write, d_addr=0x0027, d_wdata=0xAAAA_BBBB_CCCC_DDDD → mem_write high 4 cycles, mem_addr=0x0024, mem_wdata=that line, d_done pulse, d_rdata unchanged.
- Tie from reset: i_read_req and d_read_req both raised at cycle 0 → D granted first, I granted in the IDLE after d_done. A second simultaneous tie → I granted.
- d_read_req and d_write_req both high → only mem_write strobes, single d_done, num_d_access +1.
- reset_n low in the 2nd BUSY cycle → outputs 0 asynchronously, no done, state IDLE. A held request is regranted after release.
- Preload num_i_access=0xFFFF via 65535 transfers (or force) plus one more grant → 0x0000.
